stream_arbiter: RTL and testbench



---
 rtl/stream_pkg.sv | 32 +++
 rtl/stream_buf2.sv | 53 +++++
 rtl/stream_arbiter.sv | 138 +++++++++++++
 tb/tb_stream_arbiter.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/stream_pkg.sv
// rtl/stream_pkg.sv - shared types, constants and round-robin pick for stream_arbiter
package stream_pkg;

   localparam int MODE_RR    = 0;
   localparam int MODE_BURST = 1;
   localparam int MAX_CH     = 8;

   typedef enum logic {ST_IDLE, ST_HOLD} state_t;

   typedef struct packed {
      logic       found;
      logic [2:0] idx;
   } rr_pick_t;

   // First ready channel searching upward from last+1, wrapping at n.
   function automatic rr_pick_t rr_pick(input logic [MAX_CH-1:0] ready,
                                        input logic [2:0]        last,
                                        input int                n);
      rr_pick_t   res;
      logic [2:0] c;
      res = '0;
      for (int i = 1; i <= MAX_CH; i++) begin
         c = 3'((int'(last) + i) % n);
         if (i <= n && !res.found && ready[c]) begin
            res.found = 1'b1;
            res.idx   = c;
         end
      end
      return res;
   endfunction

endpackage

// File: rtl/stream_buf2.sv
// rtl/stream_buf2.sv - 2-entry fall-through {ch, data} output buffer
// Ports: i_push/i_wdata write side, i_pop read strobe, o_valid/o_rdata head word,
//        o_occ stored entry count (0..2).
module stream_buf2 #(
   parameter int W = 8
) (
   input  logic         i_clk,
   input  logic         i_rst_n,
   input  logic         i_push,
   input  logic [W-1:0] i_wdata,
   input  logic         i_pop,
   output logic         o_valid,
   output logic [W-1:0] o_rdata,
   output logic [1:0]   o_occ
);

   logic [W-1:0] mem_q [2];
   logic         rd_ptr_q;
   logic         wr_ptr_q;
   logic [1:0]   cnt_q;
   logic         empty;
   logic         wr_en;
   logic         rd_en;

   // A word arriving into an empty buffer is presented in the same cycle;
   // it is only stored if the sink does not take it right away.
   assign empty   = (cnt_q == 2'd0);
   assign o_valid = !empty || i_push;
   assign o_rdata = (empty && i_push) ? i_wdata : mem_q[rd_ptr_q];
   assign o_occ   = cnt_q;
   assign wr_en   = i_push && !(empty && i_pop);
   assign rd_en   = i_pop && !empty;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         mem_q[0] <= '0;
         mem_q[1] <= '0;
         rd_ptr_q <= 1'b0;
         wr_ptr_q <= 1'b0;
         cnt_q    <= 2'd0;
      end else begin
         if (wr_en) begin
            mem_q[wr_ptr_q] <= i_wdata;
            wr_ptr_q        <= ~wr_ptr_q;
         end
         if (rd_en) begin
            rd_ptr_q <= ~rd_ptr_q;
         end
         cnt_q <= cnt_q + {1'b0, wr_en} - {1'b0, rd_en};
      end
   end

endmodule

// File: rtl/stream_arbiter.sv
// rtl/stream_arbiter.sv - N-to-1 byte-stream arbiter, round-robin or burst-hold
// Ports: i_src_data/i_src_ready/o_src_req per-channel FIFO read side,
//        o_snk_data/o_snk_ch/o_snk_valid/i_snk_ready sink side, o_busy activity flag.
module stream_arbiter
   import stream_pkg::*;
#(
   parameter  int NUM_CH      = 2,
   parameter  int DATA_W      = 8,
   parameter  int MODE        = 0,
   parameter  int MAX_BURST   = 64,
   parameter  int IDLE_CYCLES = 4,
   localparam int CH_W        = $clog2(NUM_CH)
) (
   input  logic                     i_clk,
   input  logic                     i_rst_n,
   input  logic [NUM_CH*DATA_W-1:0] i_src_data,
   input  logic [NUM_CH-1:0]        i_src_ready,
   output logic [NUM_CH-1:0]        o_src_req,
   output logic [DATA_W-1:0]        o_snk_data,
   output logic [CH_W-1:0]          o_snk_ch,
   output logic                     o_snk_valid,
   input  logic                     i_snk_ready,
   output logic                     o_busy
);

   localparam int BW = $clog2(MAX_BURST + 1);
   localparam int IW = $clog2(IDLE_CYCLES + 1);

   state_t          state_q, state_d;
   logic [CH_W-1:0] last_q, last_d;
   logic [CH_W-1:0] lat_q, lat_d;
   logic [BW-1:0]   burst_q, burst_d;
   logic [IW-1:0]   idle_q, idle_d;
   logic            inflight_q;
   logic [CH_W-1:0] inflight_ch_q;
   logic            en_q;

   logic            issue;
   logic [CH_W-1:0] pop_ch;
   rr_pick_t        pick;
   logic            drain;
   logic            eligible;
   logic [1:0]      occ;
   logic [2:0]      demand;

   stream_buf2 #(.W(CH_W + DATA_W)) u_buf (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_push  (inflight_q),
      .i_wdata ({inflight_ch_q, i_src_data[inflight_ch_q*DATA_W +: DATA_W]}),
      .i_pop   (drain),
      .o_valid (o_snk_valid),
      .o_rdata ({o_snk_ch, o_snk_data}),
      .o_occ   (occ)
   );

   assign drain  = o_snk_valid && i_snk_ready;
   // Stored words plus the word still on its way, less what leaves now,
   // must leave room for one more pop.
   assign demand   = {1'b0, occ} + {2'b0, inflight_q} - {2'b0, drain};
   // en_q keeps o_src_req low while reset is asserted.
   assign eligible = en_q && (demand < 3'd2);
   assign o_busy   = (state_q == ST_HOLD) || inflight_q || (occ != 2'd0);

   always_comb begin
      state_d = state_q;
      last_d  = last_q;
      lat_d   = lat_q;
      burst_d = burst_q;
      idle_d  = idle_q;
      issue   = 1'b0;
      pop_ch  = lat_q;
      pick    = rr_pick(MAX_CH'(i_src_ready), 3'(last_q), NUM_CH);
      if (MODE == MODE_RR || state_q == ST_IDLE) begin
         if (eligible && pick.found && ({1'b0, pick.idx} < 4'(NUM_CH))) begin
            issue  = 1'b1;
            pop_ch = CH_W'(pick.idx);
            last_d = CH_W'(pick.idx);
            // A one-word burst is complete on its first pop, so stay idle.
            if (MODE == MODE_BURST && MAX_BURST > 1) begin
               state_d = ST_HOLD;
               lat_d   = CH_W'(pick.idx);
               burst_d = BW'(1);
               idle_d  = '0;
            end
         end
      end else begin
         last_d = lat_q;
         if (i_src_ready[lat_q]) begin
            idle_d = '0;
            if (eligible) begin
               issue   = 1'b1;
               burst_d = burst_q + BW'(1);
               if (burst_d == BW'(MAX_BURST)) begin
                  state_d = ST_IDLE;
                  burst_d = '0;
               end
            end
         end else begin
            idle_d = idle_q + IW'(1);
            if (idle_d == IW'(IDLE_CYCLES)) begin
               state_d = ST_IDLE;
               idle_d  = '0;
            end
         end
      end
   end

   always_comb begin
      o_src_req = '0;
      if (issue) begin
         o_src_req[pop_ch] = 1'b1;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q       <= ST_IDLE;
         last_q        <= CH_W'(NUM_CH - 1);
         lat_q         <= '0;
         burst_q       <= '0;
         idle_q        <= '0;
         inflight_q    <= 1'b0;
         inflight_ch_q <= '0;
         en_q          <= 1'b0;
      end else begin
         state_q       <= state_d;
         last_q        <= last_d;
         lat_q         <= lat_d;
         burst_q       <= burst_d;
         idle_q        <= idle_d;
         inflight_q    <= issue;
         inflight_ch_q <= pop_ch;
         en_q          <= 1'b1;
      end
   end

endmodule

// File: tb/tb_stream_arbiter.sv
// tb/tb_stream_arbiter.sv - self-checking bench for stream_arbiter (round-robin and burst instances)
module tb_stream_arbiter;

   localparam int NCH = 4;
   localparam int DW  = 8;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   logic [NCH*DW-1:0] src_data  [2];
   logic [NCH-1:0]    src_ready [2];
   logic [NCH-1:0]    src_req   [2];
   logic [DW-1:0]     snk_data  [2];
   logic [1:0]        snk_ch    [2];
   logic              snk_valid [2];
   logic              snk_ready [2];
   logic              busy      [2];

   stream_arbiter #(.NUM_CH(NCH), .DATA_W(DW), .MODE(0), .MAX_BURST(4), .IDLE_CYCLES(4)) dut_rr (
      .i_clk(clk), .i_rst_n(rst_n), .i_src_data(src_data[0]), .i_src_ready(src_ready[0]),
      .o_src_req(src_req[0]), .o_snk_data(snk_data[0]), .o_snk_ch(snk_ch[0]),
      .o_snk_valid(snk_valid[0]), .i_snk_ready(snk_ready[0]), .o_busy(busy[0]));

   stream_arbiter #(.NUM_CH(NCH), .DATA_W(DW), .MODE(1), .MAX_BURST(4), .IDLE_CYCLES(4)) dut_bu (
      .i_clk(clk), .i_rst_n(rst_n), .i_src_data(src_data[1]), .i_src_ready(src_ready[1]),
      .o_src_req(src_req[1]), .o_snk_data(snk_data[1]), .o_snk_ch(snk_ch[1]),
      .o_snk_valid(snk_valid[1]), .i_snk_ready(snk_ready[1]), .o_busy(busy[1]));

   int          n_tests, n_fail, cyc;
   logic [7:0]  srcq [8][$];
   logic [7:0]  expq [8][$];
   logic [7:0]  hold_data [8];
   logic [11:0] xlog [2][$];
   int          xcyc [2][$];
   int          rcyc [2][$];
   int          rch  [2][$];
   int          n_pop [2];
   int          n_xfer [2];
   int          ready_pct [2];
   logic        stall_q [2];
   logic [7:0]  prev_data [2];
   logic [1:0]  prev_ch [2];

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   function automatic logic [11:0] ent(input int ch, input int val);
      return {2'b00, 2'(ch), 8'(val)};
   endfunction

   task automatic clear_logs();
      for (int d = 0; d < 2; d++) begin
         xlog[d].delete(); xcyc[d].delete(); rcyc[d].delete(); rch[d].delete();
      end
   endtask

   // One clock cycle: drive at the falling edge, sample 1 time unit later.
   task automatic step();
      int         k;
      logic [7:0] w;
      for (int d = 0; d < 2; d++) begin
         for (int c = 0; c < NCH; c++) begin
            src_ready[d][c]          = (srcq[d*NCH+c].size() != 0);
            src_data[d][c*DW +: DW]  = hold_data[d*NCH+c];
         end
         if (ready_pct[d] >= 100)    snk_ready[d] = 1'b1;
         else if (ready_pct[d] <= 0) snk_ready[d] = 1'b0;
         else                        snk_ready[d] = ($urandom_range(99) < ready_pct[d]);
      end
      #1;
      for (int d = 0; d < 2; d++) begin
         check_eq("req_vs_ready", 32'(src_req[d] & ~src_ready[d]), 0);
         check_eq("req_onehot", 32'($countones(src_req[d]) <= 1), 1);
         if (stall_q[d]) begin
            check_eq("stall_valid", 32'(snk_valid[d]), 1);
            check_eq("stall_data", 32'(snk_data[d]), 32'(prev_data[d]));
            check_eq("stall_ch", 32'(snk_ch[d]), 32'(prev_ch[d]));
         end
         if (snk_valid[d] && snk_ready[d]) begin
            k = d*NCH + int'(snk_ch[d]);
            check_eq("xfer_expected", 32'(expq[k].size() != 0), 1);
            if (expq[k].size() != 0) begin
               w = expq[k].pop_front();
               check_eq("xfer_word", 32'(snk_data[d]), 32'(w));
            end
            xlog[d].push_back({2'b00, snk_ch[d], snk_data[d]});
            xcyc[d].push_back(cyc);
            n_xfer[d]++;
         end
         stall_q[d]   = snk_valid[d] && !snk_ready[d];
         prev_data[d] = snk_data[d];
         prev_ch[d]   = snk_ch[d];
         for (int c = 0; c < NCH; c++) begin
            k = d*NCH + c;
            if (src_req[d][c] && srcq[k].size() != 0) begin
               w = srcq[k].pop_front();
               hold_data[k] = w;
               expq[k].push_back(w);
               rcyc[d].push_back(cyc);
               rch[d].push_back(c);
               n_pop[d]++;
            end
         end
         check_eq("buffered_max", 32'((n_pop[d] - n_xfer[d]) <= 2), 1);
      end
      cyc++;
      @(negedge clk);
   endtask

   task automatic run_until(input int d, input int target, input int budget, input string tag);
      for (int i = 0; i < budget && n_xfer[d] < target; i++) step();
      check_eq(tag, 32'(n_xfer[d] >= target), 1);
   endtask

   task automatic drop_in_flight();
      for (int i = 0; i < 8; i++) begin
         expq[i].delete();
         hold_data[i] = '0;
      end
      for (int d = 0; d < 2; d++) begin
         stall_q[d] = 1'b0;
         n_pop[d]   = n_xfer[d];
      end
   endtask

   initial begin
      #5000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int          last0, first1, cnt0, cnt3, p0, x0, rem;
      logic [11:0] e;
      n_tests = 0; n_fail = 0; cyc = 0;
      rst_n = 1'b0;
      for (int d = 0; d < 2; d++) begin
         src_data[d] = '0; src_ready[d] = '0; snk_ready[d] = 1'b0;
         n_pop[d] = 0; n_xfer[d] = 0; ready_pct[d] = 100; stall_q[d] = 1'b0;
         prev_data[d] = '0; prev_ch[d] = '0;
      end
      for (int i = 0; i < 8; i++) hold_data[i] = '0;
      @(negedge clk); @(negedge clk);

      for (int d = 0; d < 2; d++) begin
         check_eq("rst_req", 32'(src_req[d]), 0);
         check_eq("rst_valid", 32'(snk_valid[d]), 0);
         check_eq("rst_data", 32'(snk_data[d]), 0);
         check_eq("rst_ch", 32'(snk_ch[d]), 0);
         check_eq("rst_busy", 32'(busy[d]), 0);
      end
      rst_n = 1'b1;

      // Round-robin interleave of two 3-word sources.
      clear_logs();
      for (int i = 0; i < 3; i++) begin
         srcq[0].push_back(8'(8'hA0 + i));
         srcq[1].push_back(8'(8'hB0 + i));
      end
      run_until(0, 6, 40, "t1_done");
      for (int i = 0; i < 6; i++) begin
         e = ent(i % 2, ((i % 2) ? 'hB0 : 'hA0) + i / 2);
         if (xlog[0].size() > i) check_eq("t1_word", 32'(xlog[0][i]), 32'(e));
      end
      if (xcyc[0].size() >= 6 && rcyc[0].size() > 0) begin
         check_eq("t1_latency", 32'(xcyc[0][0] - rcyc[0][0]), 1);
         check_eq("t1_back_to_back", 32'(xcyc[0][5] - xcyc[0][0]), 5);
      end

      // Burst mode: 10 words on ch0, 2 on ch1.
      clear_logs();
      for (int i = 0; i < 10; i++) srcq[4].push_back(8'(i));
      for (int i = 0; i < 2; i++)  srcq[5].push_back(8'(8'h10 + i));
      run_until(1, 12, 80, "t2_done");
      for (int i = 0; i < 12; i++) begin
         if (i < 4)      e = ent(0, i);
         else if (i < 6) e = ent(1, 'h10 + i - 4);
         else            e = ent(0, i - 2);
         if (xlog[1].size() > i) check_eq("t2_word", 32'(xlog[1][i]), 32'(e));
      end
      repeat (8) step();

      // Burst mode idle timeout: ch0 runs dry after 2 words, ch1 waiting.
      clear_logs();
      srcq[4].push_back(8'h20); srcq[4].push_back(8'h21);
      step();
      for (int i = 0; i < 3; i++) srcq[5].push_back(8'(8'h30 + i));
      run_until(1, n_xfer[1] + 4, 60, "t3_done");
      last0 = -1; first1 = -1; cnt0 = 0;
      for (int i = 0; i < rch[1].size(); i++) begin
         if (rch[1][i] == 0) begin last0 = rcyc[1][i]; cnt0++; end
         if (rch[1][i] == 1 && first1 < 0) first1 = rcyc[1][i];
      end
      check_eq("t3_ch0_pops", 32'(cnt0), 2);
      check_eq("t3_idle_gap", 32'(first1 - last0 - 1), 4);
      repeat (8) step();

      // Sink stall in round-robin mode.
      clear_logs();
      x0 = n_xfer[0];
      for (int i = 0; i < 8; i++) begin
         srcq[0].push_back(8'(8'h40 + i));
         srcq[1].push_back(8'(8'h50 + i));
      end
      repeat (3) step();
      ready_pct[0] = 0;
      p0 = n_pop[0];
      repeat (10) step();
      check_eq("t4_stall_pops", 32'((n_pop[0] - p0) <= 2), 1);
      check_eq("t4_stall_busy", 32'(busy[0]), 1);
      ready_pct[0] = 100;
      run_until(0, x0 + 16, 80, "t4_done");
      check_eq("t4_words", 32'(xlog[0].size()), 16);

      // Only ch3 ready on the burst instance.
      clear_logs();
      for (int i = 0; i < 6; i++) srcq[7].push_back(8'(8'h60 + i));
      run_until(1, n_xfer[1] + 6, 40, "t5_done");
      cnt3 = 0;
      for (int i = 0; i < xlog[1].size(); i++) if (xlog[1][i][9:8] == 2'd3) cnt3++;
      check_eq("t5_tag3", 32'(cnt3), 6);
      repeat (8) step();

      // Asynchronous reset in the middle of a burst.
      for (int i = 0; i < 10; i++) srcq[7].push_back(8'(8'h70 + i));
      repeat (3) step();
      check_eq("t5_busy_before_rst", 32'(busy[1]), 1);
      #2 rst_n = 1'b0;
      #1;
      check_eq("t5_rst_req", 32'(src_req[1]), 0);
      check_eq("t5_rst_valid", 32'(snk_valid[1]), 0);
      check_eq("t5_rst_data", 32'(snk_data[1]), 0);
      check_eq("t5_rst_ch", 32'(snk_ch[1]), 0);
      check_eq("t5_rst_busy", 32'(busy[1]), 0);
      drop_in_flight();
      @(negedge clk); @(negedge clk);
      rst_n = 1'b1;
      clear_logs();
      srcq[4].push_back(8'h80); srcq[4].push_back(8'h81);
      for (int i = 0; i < 10 && rch[1].size() == 0; i++) step();
      check_eq("t5_first_req_seen", 32'(rch[1].size() != 0), 1);
      if (rch[1].size() != 0) check_eq("t5_first_ch", 32'(rch[1][0]), 0);

      // Random traffic and backpressure on both instances.
      for (int t = 0; t < 10000; t++) begin
         if (t % 500 == 0) begin
            ready_pct[0] = $urandom_range(100, 20);
            ready_pct[1] = $urandom_range(100, 20);
         end
         for (int d = 0; d < 2; d++) begin
            if ($urandom_range(2) == 0) begin
               p0 = d*NCH + int'($urandom_range(3));
               if (srcq[p0].size() < 6) srcq[p0].push_back(8'($urandom));
            end
         end
         step();
      end
      ready_pct[0] = 100; ready_pct[1] = 100;
      rem = 1;
      for (int i = 0; i < 400 && rem != 0; i++) begin
         step();
         rem = 0;
         for (int k = 0; k < 8; k++) rem += srcq[k].size() + expq[k].size();
      end
      check_eq("rand_drained", 32'(rem), 0);
      check_eq("rand_count_rr", 32'(n_pop[0] - n_xfer[0]), 0);
      check_eq("rand_count_burst", 32'(n_pop[1] - n_xfer[1]), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
